// File: rtl/tinychip_pkg.sv
// Shared widths, default opcodes and state encoding for the tinychip fetch path.
package tinychip_pkg;
  localparam int INSTR_W = 9;
  localparam int ADDR_W  = 8;

  localparam logic [INSTR_W-1:0] HALT_OP_DEFAULT = 9'h1FF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection: start load, branch redirect, sequential increment or hold.
module fetch_next_pc
  import tinychip_pkg::*;
#(
  parameter logic [ADDR_W-1:0] START_ADDR = 8'h00
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              load_start_i,
  input  logic              issue_i,
  input  logic              branch_take_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              at_last_i,
  output logic [ADDR_W-1:0] pc_d_o
);

  always_comb begin
    pc_d_o = pc_i;
    if (load_start_i) begin
      pc_d_o = START_ADDR;
    end else if (issue_i) begin
      if (branch_take_i) begin
        pc_d_o = branch_target_i;
      end else if (!at_last_i) begin
        // Issuing the last address without a branch ends the program, so the PC never wraps.
        pc_d_o = pc_i + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Zero-latency instruction fetch sequencer: issues imem_instr in the cycle it is addressed.
// Handshake: instr is meaningful only when instr_valid=1; stall=1 holds the PC with no issue.
module fetch_controller
  import tinychip_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  START_ADDR = 8'h00,
  parameter logic [ADDR_W-1:0]  LAST_ADDR  = 8'hFF,
  parameter logic [INSTR_W-1:0] HALT_OP    = HALT_OP_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_take,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               done,
  output logic [15:0]        issue_count,
  output fetch_state_t       state
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              issue;
  logic              load_start;
  logic              at_last;

  assign at_last = (pc_q == LAST_ADDR);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    issue      = 1'b0;
    load_start = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          load_start = 1'b1;
          cnt_d      = '0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (imem_instr == HALT_OP) begin
            state_d = S_HALT;
          end else begin
            issue = 1'b1;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            if (at_last && !branch_take) state_d = S_HALT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  fetch_next_pc #(
    .START_ADDR(START_ADDR)
  ) u_next_pc (
    .pc_i           (pc_q),
    .load_start_i   (load_start),
    .issue_i        (issue),
    .branch_take_i  (branch_take),
    .branch_target_i(branch_target),
    .at_last_i      (at_last),
    .pc_d_o         (pc_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_ADDR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = issue;
  assign instr       = issue ? imem_instr : '0;
  assign done        = (state_q == S_HALT);
  assign issue_count = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller (LAST_ADDR=5): directed vector table, corner sequences, random vs model.
module tb_fetch_controller;
  import tinychip_pkg::*;

  localparam logic [7:0] LAST = 8'h05;
  localparam logic [8:0] HOP  = 9'h1FF;

  logic        clk = 1'b0;
  logic        reset, start, stall, branch_take;
  logic [7:0]  branch_target, imem_addr, pc;
  logic [8:0]  imem_instr, instr;
  logic        instr_valid, done;
  logic [15:0] issue_count;
  fetch_state_t state;

  logic [8:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr];

  fetch_controller #(
    .START_ADDR(8'h00),
    .LAST_ADDR (LAST),
    .HALT_OP   (HOP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .branch_take  (branch_take),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .done         (done),
    .issue_count  (issue_count),
    .state        (state)
  );

  typedef struct {
    logic        rst, st, sl, br;
    logic [7:0]  tgt;
    logic [7:0]  e_pc;
    logic        e_v;
    logic [8:0]  e_instr;
    logic        e_done;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, sl, br, input logic [7:0] tgt, e_pc, input logic e_v,
                     input logic [8:0] e_instr, input logic e_done, input logic [15:0] e_cnt);
    vec_t v;
    v.rst = 1'b0; v.st = st; v.sl = sl; v.br = br; v.tgt = tgt;
    v.e_pc = e_pc; v.e_v = e_v; v.e_instr = e_instr; v.e_done = e_done; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs mid-cycle, then let combinational outputs settle before sampling.
  task automatic step(input logic rst, st, sl, br, input logic [7:0] tgt);
    @(negedge clk);
    reset = rst; start = st; stall = sl; branch_take = br; branch_target = tgt;
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_pc, input logic e_v,
                         input logic [8:0] e_instr, input logic e_done, input logic [15:0] e_cnt);
    chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
    chk({tag, ".imem_addr"}, 32'(imem_addr), 32'(e_pc));
    chk({tag, ".valid"}, 32'(instr_valid), 32'(e_v));
    chk({tag, ".instr"}, 32'(instr), 32'(e_instr));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".count"}, 32'(issue_count), 32'(e_cnt));
  endtask

  // Reference model: program state as "running"/"halted" flags plus PC and counter.
  logic        m_run, m_halt;
  logic [7:0]  m_pc;
  int          m_cnt;

  task automatic model_reset();
    m_run = 1'b0; m_halt = 1'b0; m_pc = 8'h00; m_cnt = 0;
  endtask

  task automatic model_step(input logic rst, st, sl, br, input logic [7:0] tgt);
    logic [8:0] op;
    op = mem[m_pc];
    if (rst) begin
      model_reset();
    end else if (!m_run && st) begin
      m_run = 1'b1; m_halt = 1'b0; m_pc = 8'h00; m_cnt = 0;
    end else if (m_run && !sl) begin
      if (op == HOP) begin
        m_run = 1'b0; m_halt = 1'b1;
      end else begin
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        if (br) m_pc = tgt;
        else if (m_pc == LAST) begin
          m_run = 1'b0; m_halt = 1'b1;
        end else m_pc = m_pc + 8'd1;
      end
    end
  endtask

  initial begin
    logic r, s, sl, b;
    logic [7:0] t;
    logic iss;

    for (int i = 0; i < 256; i++) mem[i] = 9'h000;
    mem[0] = 9'h011; mem[1] = 9'h022; mem[2] = 9'h033; mem[3] = 9'h1FF;
    mem[8'h40] = 9'h144; mem[8'h41] = 9'h1FF;

    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_take = 1'b0; branch_target = 8'h00;
    repeat (2) @(posedge clk);

    // Directed table: straight run to HALT_OP, restart from HALT, stalls, branch, branch under stall.
    add(0,0,0,8'h00, 8'h00,0,9'h000,0,0);
    add(1,0,0,8'h00, 8'h00,0,9'h000,0,0);
    add(0,0,0,8'h00, 8'h00,1,9'h011,0,0);
    add(0,0,0,8'h00, 8'h01,1,9'h022,0,1);
    add(0,0,0,8'h00, 8'h02,1,9'h033,0,2);
    add(0,0,0,8'h00, 8'h03,0,9'h000,0,3);
    add(0,0,0,8'h00, 8'h03,0,9'h000,1,3);
    add(1,0,0,8'h00, 8'h03,0,9'h000,1,3);
    add(1,0,0,8'h00, 8'h00,1,9'h011,0,0);
    add(0,1,0,8'h00, 8'h01,0,9'h000,0,1);
    add(0,1,0,8'h00, 8'h01,0,9'h000,0,1);
    add(0,0,0,8'h00, 8'h01,1,9'h022,0,1);
    add(1,1,1,8'h40, 8'h02,0,9'h000,0,2);
    add(0,0,1,8'h40, 8'h02,1,9'h033,0,2);
    add(0,0,0,8'h00, 8'h40,1,9'h144,0,3);
    add(0,0,0,8'h00, 8'h41,0,9'h000,0,4);
    add(0,0,0,8'h00, 8'h41,0,9'h000,1,4);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].sl, tbl[i].br, tbl[i].tgt);
      chk_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_v, tbl[i].e_instr,
              tbl[i].e_done, tbl[i].e_cnt);
    end

    // LAST_ADDR end of program: no wrap, then branch at LAST_ADDR, then reset mid-RUN.
    step(1,0,0,0,8'h00);
    for (int i = 0; i < 6; i++) mem[i] = 9'h0A0 + 9'(i);
    mem[8'h20] = 9'h0C3;
    step(0,0,0,0,8'h00);
    chk("idle.state", 32'(state), 32'(S_IDLE));
    chk_all("idle", 8'h00, 0, 9'h000, 0, 0);
    step(0,1,0,0,8'h00);
    for (int i = 0; i < 6; i++) begin
      step(0,0,0,0,8'h00);
      chk_all($sformatf("last_run%0d", i), 8'(i), 1, 9'h0A0 + 9'(i), 0, 16'(i));
    end
    step(0,0,0,0,8'h00);
    chk_all("last_halt", 8'h05, 0, 9'h000, 1, 6);
    step(0,0,0,0,8'h00);
    chk_all("last_halt_hold", 8'h05, 0, 9'h000, 1, 6);
    step(0,1,0,0,8'h00);
    for (int i = 0; i < 5; i++) step(0,0,0,0,8'h00);
    step(0,0,0,1,8'h20);
    chk_all("last_branch", 8'h05, 1, 9'h0A5, 0, 5);
    step(1,0,0,0,8'h00);
    chk_all("pre_reset", 8'h20, 1, 9'h0C3, 0, 6);
    step(0,0,0,0,8'h00);
    chk("post_reset.state", 32'(state), 32'(S_IDLE));
    chk_all("post_reset", 8'h00, 0, 9'h000, 0, 0);

    // Counter saturation: branch to self at 0 every cycle.
    mem[0] = 9'h055;
    step(0,1,0,0,8'h00);
    for (int k = 0; k <= 65536; k++) begin
      step(0,0,0,1,8'h00);
      if (k == 65534) chk("sat_fffe", 32'(issue_count), 32'h0000FFFE);
      if (k == 65535) chk("sat_ffff", 32'(issue_count), 32'h0000FFFF);
      if (k == 65536) begin
        chk("sat_hold", 32'(issue_count), 32'h0000FFFF);
        chk("sat_valid", 32'(instr_valid), 32'h1);
      end
    end

    // Random phase against the reference model.
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? HOP : 9'($urandom_range(0, 510));
    step(1,0,0,0,8'h00);
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 7) == 0);
      sl = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 7) == 0);
      t  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
      step(r, s, sl, b, t);
      iss = m_run && !sl && (mem[m_pc] != HOP);
      chk_all($sformatf("rnd%0d", c), m_pc, iss, iss ? mem[m_pc] : 9'h000, m_halt, 16'(m_cnt));
      model_step(r, s, sl, b, t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
